// File: rtl/multicycle_adder_pkg.sv
// Shared state encoding and chunk-count derivation for the multicycle adder and its bench.
package multicycle_adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunk additions needed for one operation.
  function automatic int unsigned calc_nch(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/multicycle_adder_chunk.sv
// One-bit full adder cell and the CHUNK-bit ripple adder built from it.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module adder_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  // Ripple chain; each stage keeps its own carry nets so the chain has no self-referencing vector.
  for (genvar i = 0; i < W; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .s    (s[i]),
      .cout (co)
    );
  end

  assign cout = g_fa[W-1].co;
  assign cmsb = g_fa[W-1].ci;

endmodule

// File: rtl/multicycle_adder.sv
// Add/subtract WIDTH-bit operands CHUNK bits per clock using one shared chunk adder.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  localparam int unsigned NCH = calc_nch(WIDTH, CHUNK);
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     idx;
  logic              accept;
  logic              last;

  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry;
  logic [CHUNK-1:0]  a_ch;
  logic [CHUNK-1:0]  b_ch;
  logic [CHUNK-1:0]  s_ch;
  logic              cout_ch;
  logic              cmsb_ch;

  assign accept = (state == IDLE) && start;
  assign last   = (idx == LAST_IDX);
  assign a_ch   = a_r[idx*CHUNK +: CHUNK];
  assign b_ch   = b_r[idx*CHUNK +: CHUNK];

  adder_chunk #(.W(CHUNK)) u_chunk (
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry),
    .s    (s_ch),
    .cout (cout_ch),
    .cmsb (cmsb_ch)
  );

  // Control: state register and chunk index counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx <= '0;
      end else if (state == RUN) begin
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture (b pre-inverted for subtract) and chunked result accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= '0;
      b_r      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b ^ {WIDTH{sub}};
      carry <= sub;
    end else if (state == RUN) begin
      sum[idx*CHUNK +: CHUNK] <= s_ch;
      carry                   <= cout_ch;
      if (last) begin
        sum[WIDTH] <= cout_ch;
        overflow   <= cmsb_ch ^ cout_ch;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder at WIDTH=16, CHUNK=4.
module tb_multicycle_adder;
  import multicycle_adder_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned NCH   = calc_nch(WIDTH, CHUNK);

  typedef struct packed {
    logic [WIDTH:0] sum;
    logic           ovf;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH:0]   sum;
  logic             overflow;

  int   vectors;
  int   miscompares;
  exp_t sb[$];

  multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic: WIDTH+1 bit result, overflow from operand/result signs.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   r;
    exp_t             e;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, s};
    e.sum = r;
    if (s) e.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    else   e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if (sum !== '0) begin miscompares++; $display("FAIL reset_sum: got %h want 0", sum); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    // Reset must win over a simultaneous start.
    start = 1'b1; a = 16'h1234; b = 16'h1111;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_dominates_start: ready got %b want 1", ready); end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL reset_release_idle: ready %b done %b want 1 0", ready, done);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    exp_t e;
    bit   got;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL op_ready_before: got %b want 1", ready); end
    start = 1'b1; a = x; b = y; sub = s;
    sb.push_back(model(x, y, s));
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
      end
      if (done === 1'b1) begin
        got = 1'b1;
        e = sb.pop_front();
        vectors++;
        if (k != int'(NCH + 1)) begin
          miscompares++; $display("FAIL op_latency: got %0d edges want %0d", k, NCH + 1);
        end
        vectors++;
        if (sum !== e.sum) begin
          miscompares++; $display("FAIL op_sum a=%h b=%h sub=%b: got %h want %h", x, y, s, sum, e.sum);
        end
        vectors++;
        if (overflow !== e.ovf) begin
          miscompares++; $display("FAIL op_ovf a=%h b=%h sub=%b: got %b want %b", x, y, s, overflow, e.ovf);
        end
      end else begin
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL op_ready_busy: got %b want 0 at k=%0d", ready, k); end
      end
    end
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL op_timeout: done not seen, got 0 want 1");
      void'(sb.pop_front());
    end else begin
      @(negedge clk);
      if (sum !== e.sum || overflow !== e.ovf || ready !== 1'b1) begin
        miscompares++;
        $display("FAIL op_hold: sum %h ovf %b ready %b want %h %b 1", sum, overflow, ready, e.sum, e.ovf);
      end
    end
  endtask

  task automatic test_vectors();
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0);
    for (int i = 0; i < 8; i++) run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
  endtask

  task automatic test_ignore_start();
    exp_t e;
    bit   bad;
    @(negedge clk);
    start = 1'b1; a = 16'h1357; b = 16'h2468; sub = 1'b0;
    sb.push_back(model(16'h1357, 16'h2468, 1'b0));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = (k == 2); a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
      vectors++;
      if (ready !== 1'b0) begin miscompares++; $display("FAIL ignore_ready_busy: got %b want 0 k=%0d", ready, k); end
    end
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (done !== 1'b1 || sum !== e.sum || overflow !== e.ovf) begin
      miscompares++;
      $display("FAIL ignore_result: done %b sum %h ovf %b want 1 %h %b", done, sum, overflow, e.sum, e.ovf);
    end
    start = 1'b1; a = 16'h0F0F; b = 16'h0101;
    @(negedge clk);
    start = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      if (done !== 1'b0 || ready !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL ignore_not_queued: extra operation seen, got busy want idle"); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    @(negedge clk);
    start = 1'b1; a = 16'h4321; b = 16'h1234; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL abort_state: ready %b done %b want 1 0", ready, done);
    end
    vectors++;
    if (sum !== '0 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL abort_clear: sum %h ovf %b want 0 0", sum, overflow);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL abort_no_done: got done pulse want none"); end
    run_op(16'h4321, 16'h1234, 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   rdy_exp;
    bit   done_exp;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 36; k++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
      rdy_exp  = (k % 6 == 0);
      done_exp = (k % 6 == 5);
      if (rdy_exp) sb.push_back(model(a, b, sub));
      vectors++;
      if (ready !== rdy_exp) begin miscompares++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, ready, rdy_exp); end
      vectors++;
      if (done !== done_exp) begin miscompares++; $display("FAIL b2b_done k=%0d: got %b want %b", k, done, done_exp); end
      if (done_exp) begin
        e = sb.pop_front();
        vectors++;
        if (sum !== e.sum || overflow !== e.ovf) begin
          miscompares++;
          $display("FAIL b2b_result k=%0d: sum %h ovf %b want %h %b", k, sum, overflow, e.sum, e.ovf);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an operation; sampled only when ready=1.
REQ-006 SHALL have port sub  input  1  0 = a+b, 1 = a-b; captured with start.
REQ-007 SHALL have port a  input  WIDTH  first operand; captured with start.
REQ-008 SHALL have port b  input  WIDTH  second operand; captured with start.
REQ-009 SHALL have port ready  output  1  high only in IDLE; start is accepted only while high.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port sum  output  WIDTH+1  result; sum[WIDTH] is final carry-out (for sub: 1 = no borrow).
REQ-012 SHALL have port overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 at an edge, SHALL capture a, b, sub, set chunk index to 0, set carry to sub, and enter RUN.
REQ-015 In RUN, each edge SHALL add chunk idx of a and (b XOR {WIDTH{sub}}) with the stored carry, write CHUNK result bits into sum at chunk position idx, store the chunk carry-out, and increment idx.
REQ-016 After NCH RUN edges, SHALL enter DONE, writing sum[WIDTH] = final carry and overflow = carry into MSB XOR carry out of MSB.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE; the next edge SHALL return to IDLE.
REQ-018 Latency: done SHALL be observed high after exactly NCH+1 rising edges counted from the edge that accepted start.
REQ-019 sum and overflow SHALL hold their last result from DONE until the next accepted start; they are undefined-free (never X) but need not be meaningful during RUN.
REQ-020 start while in RUN or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-021 Input changes on a, b, sub after acceptance SHALL NOT affect the in-flight result.
REQ-022 With CHUNK = WIDTH, behaviour SHALL degrade to a single RUN cycle (NCH = 1) with identical timing rules.
REQ-023 Arithmetic SHALL be modulo 2^(WIDTH+1) with sum[WIDTH] as carry; no saturation.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, ready=1, done=0, sum=0, overflow=0, idx=0, carry=0, regardless of state.
REQ-025 Reset during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-026 reset SHALL dominate start on the same edge.

Structure
REQ-027 State encodings and the NCH derivation SHALL live in a shared package/header used by this block and its bench.
REQ-028 The per-cycle chunk adder SHALL be a sub-module adder_chunk (CHUNK-bit ripple of the existing full_adder cells, carry in/out).
REQ-029 Control (state, idx counter) and datapath (operand, sum registers) SHALL be separate always blocks in multicycle_adder.

Verification (WIDTH=16, CHUNK=4)
REQ-030 a=0xFFFF, b=0x0001, sub=0, start -> done on 5th edge, sum=0x10000, overflow=0.
REQ-031 a=0x0005, b=0x0007, sub=1 -> sum=0x0FFFE (sum[16]=0, borrow), overflow=0; a=0x8000, b=0x0001, sub=1 -> sum=0x17FFF, overflow=1.
REQ-032 a=0x7FFF, b=0x0001, sub=0 -> sum=0x08000, overflow=1.
REQ-033 start pulsed during RUN with different operands -> ignored, first result unchanged, ready stays 0 until IDLE.
REQ-034 reset asserted on 2nd RUN edge -> IDLE next cycle, sum=0, no done pulse; new start then completes normally.
REQ-035 start held high continuously -> back-to-back operations, done every 6 cycles, each result matching captured operands.
